// File: rtl/serdes_cipher_engine.sv
`default_nettype none
// ============================================================================
// Module : serdes_cipher_engine
// Brief  : Two-lane serial word capture, XOR with a rotating key segment,
//          serial ciphertext emit with output backpressure.
// Rev    : 1.0  initial release
// ============================================================================
module serdes_cipher_engine #(
    parameter int W         = 8,
    parameter int KEY_W     = 128,
    parameter int LEN_W     = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] frame_len,
    input  logic [KEY_W-1:0] key,
    input  logic             a_bit,
    input  logic             b_bit,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             cipher_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             done,
    output logic [LEN_W-1:0] word_idx
);

    localparam int NSEG  = KEY_W / W;
    localparam int CNT_W = $clog2(W) + 1;

    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(W - 1);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);
    localparam logic [LEN_W-1:0] c_idx_one  = LEN_W'(1);

    localparam logic [1:0] c_st_idle    = 2'd0;
    localparam logic [1:0] c_st_shift   = 2'd1;
    localparam logic [1:0] c_st_encrypt = 2'd2;
    localparam logic [1:0] c_st_output  = 2'd3;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [W-1:0]     r_a;
    logic [W-1:0]     r_b;
    logic [W-1:0]     r_enc;
    logic [W-1:0]     w_enc_shift;
    logic [W-1:0]     w_key_seg;
    logic             w_emit_bit;
    logic [CNT_W-1:0] r_bit_cnt;
    logic [LEN_W-1:0] r_word_idx;
    logic [LEN_W-1:0] r_len;
    logic [KEY_W-1:0] r_key;
    logic             r_done;
    logic [31:0]      w_seg_idx;
    logic             w_in_fire;
    logic             w_last_in;
    logic             w_out_fire;
    logic             w_last_out;
    logic             w_frame_end;

    assign w_in_fire   = (r_state == c_st_shift) && in_valid;
    assign w_last_in   = w_in_fire && (r_bit_cnt == c_cnt_last);
    assign w_out_fire  = (r_state == c_st_output) && out_ready;
    assign w_last_out  = w_out_fire && (r_bit_cnt == c_cnt_last);
    assign w_frame_end = w_last_out && (r_word_idx == r_len);

    // Key segment rotates with the word index; segment 0 sits in the LSBs.
    assign w_seg_idx = 32'(r_word_idx) % 32'(NSEG);
    assign w_key_seg = W'(r_key >> (w_seg_idx * W));

    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            assign w_emit_bit  = r_enc[W-1];
            assign w_enc_shift = {r_enc[W-2:0], 1'b0};
        end else begin : g_lsb_first
            assign w_emit_bit  = r_enc[0];
            assign w_enc_shift = {1'b0, r_enc[W-1:1]};
        end
    endgenerate

    assign in_ready   = (r_state == c_st_shift);
    assign out_valid  = (r_state == c_st_output);
    assign busy       = (r_state != c_st_idle);
    assign cipher_out = out_valid & w_emit_bit;
    assign done       = r_done;
    assign word_idx   = r_word_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= c_st_idle;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle:    if (start) w_state_nxt = c_st_shift;
            c_st_shift:   if (w_last_in) w_state_nxt = c_st_encrypt;
            c_st_encrypt: w_state_nxt = c_st_output;
            c_st_output:  if (w_last_out) w_state_nxt = w_frame_end ? c_st_idle : c_st_shift;
            default:      w_state_nxt = c_st_idle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a        <= '0;
            r_b        <= '0;
            r_enc      <= '0;
            r_bit_cnt  <= '0;
            r_word_idx <= '0;
            r_key      <= '0;
            r_len      <= '0;
            r_done     <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_key      <= key;
                        r_len      <= frame_len;
                        r_word_idx <= '0;
                        r_bit_cnt  <= '0;
                        r_a        <= '0;
                        r_b        <= '0;
                        r_done     <= 1'b0;
                    end
                end
                c_st_shift: begin
                    if (w_in_fire) begin
                        r_a       <= {r_a[W-2:0], a_bit};
                        r_b       <= {r_b[W-2:0], b_bit};
                        r_bit_cnt <= r_bit_cnt + c_cnt_one;
                    end
                end
                c_st_encrypt: begin
                    r_enc     <= r_a ^ r_b ^ w_key_seg;
                    r_bit_cnt <= '0;
                end
                default: begin
                    if (w_out_fire) begin
                        r_enc     <= w_enc_shift;
                        r_bit_cnt <= r_bit_cnt + c_cnt_one;
                        if (w_frame_end) begin
                            r_done <= 1'b1;
                        end else if (w_last_out) begin
                            r_word_idx <= r_word_idx + c_idx_one;
                            r_a        <= '0;
                            r_b        <= '0;
                            r_bit_cnt  <= '0;
                        end
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serdes_cipher_engine.sv
`default_nettype none
// ============================================================================
// Module : tb_serdes_cipher_engine
// Brief  : Word-level reference model and per-cycle serial stream checking.
// Rev    : 1.0  initial release
// ============================================================================
module tb_serdes_cipher_engine;

    localparam logic [127:0] c_key = 128'hA1B2C3D4E5F60123456789ABCDEF1234;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         start_s [2];
    logic         a_s     [2];
    logic         b_s     [2];
    logic         iv_s    [2];
    logic         or_s    [2];
    logic [4:0]   fl_s    [2];
    logic [127:0] key_s   [2];
    logic         irdy    [2];
    logic         ov      [2];
    logic         co      [2];
    logic         bsy     [2];
    logic         dn      [2];
    logic [3:0]   wi0;
    logic [4:0]   wi1;

    // Instance 0: MSB first, 4-bit length; instance 1: LSB first, 5-bit length.
    serdes_cipher_engine #(.W(8), .KEY_W(128), .LEN_W(4), .MSB_FIRST(1)) dut0 (
        .clk(clk), .rst(rst), .start(start_s[0]), .frame_len(fl_s[0][3:0]),
        .key(key_s[0]), .a_bit(a_s[0]), .b_bit(b_s[0]), .in_valid(iv_s[0]),
        .in_ready(irdy[0]), .cipher_out(co[0]), .out_valid(ov[0]),
        .out_ready(or_s[0]), .busy(bsy[0]), .done(dn[0]), .word_idx(wi0));

    serdes_cipher_engine #(.W(8), .KEY_W(128), .LEN_W(5), .MSB_FIRST(0)) dut1 (
        .clk(clk), .rst(rst), .start(start_s[1]), .frame_len(fl_s[1]),
        .key(key_s[1]), .a_bit(a_s[1]), .b_bit(b_s[1]), .in_valid(iv_s[1]),
        .in_ready(irdy[1]), .cipher_out(co[1]), .out_valid(ov[1]),
        .out_ready(or_s[1]), .busy(bsy[1]), .done(dn[1]), .word_idx(wi1));

    logic [7:0] stim_a [0:63];
    logic [7:0] stim_b [0:63];
    logic [7:0] exp_w  [2][0:63];
    logic [7:0] rcv    [2][0:63];
    int         nw     [2];
    int         pos    [2];
    int         fid    [2];
    int         or_mode[2];
    int         errors = 0;
    int         checks = 0;

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic int cur_wi(input int d);
        return (d == 0) ? int'(wi0) : int'(wi1);
    endfunction

    // Per-cycle compare against the expected word list of the current frame.
    int         seen [2] = '{0, 0};
    int         wn, bn, bidx;
    logic [7:0] ew;
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (seen[d] != fid[d]) begin
                seen[d] = fid[d];
                pos[d]  = 0;
            end
            if (!rst) begin
                chk(!(ov[d] && irdy[d]), "hs_exclusive", 32'(ov[d]), 32'(0));
                if (bsy[d]) begin
                    chk(dn[d] == 1'b0, "done_while_busy", 32'(dn[d]), 32'(0));
                    chk(cur_wi(d) == pos[d] / 8, "word_idx", 32'(cur_wi(d)), 32'(pos[d] / 8));
                end
                if (!ov[d]) begin
                    chk(co[d] == 1'b0, "cipher_idle_zero", 32'(co[d]), 32'(0));
                end else begin
                    wn = pos[d] / 8;
                    bn = pos[d] % 8;
                    chk(wn < nw[d], "stream_overrun", 32'(wn), 32'(nw[d]));
                    if (wn < nw[d]) begin
                        bidx = (d == 0) ? 7 - bn : bn;
                        ew   = exp_w[d][wn];
                        chk(co[d] == ew[bidx], "cipher_bit", 32'(co[d]), 32'(ew[bidx]));
                        if (or_s[d]) begin
                            rcv[d][wn][bidx] = co[d];
                            pos[d]           = pos[d] + 1;
                        end
                    end
                end
            end
        end
    end

    // Sink: always ready, random, or a 3-cycle stall after the third bit.
    int sid [2] = '{0, 0};
    int sc  [2] = '{0, 0};
    always begin
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            if (sid[d] != fid[d]) begin
                sid[d] = fid[d];
                sc[d]  = 0;
            end
            case (or_mode[d])
                0: or_s[d] = 1'b1;
                1: or_s[d] = 1'($urandom % 2);
                default: begin
                    if (pos[d] == 3 && sc[d] < 3) begin
                        or_s[d] = 1'b0;
                        sc[d]   = sc[d] + 1;
                    end else begin
                        or_s[d] = 1'b1;
                    end
                end
            endcase
        end
    end

    task automatic check_all_zero(input int d, input string name);
        chk(ov[d] == 0 && co[d] == 0 && bsy[d] == 0 && dn[d] == 0 && irdy[d] == 0 && cur_wi(d) == 0,
            name, {ov[d], co[d], bsy[d], dn[d], irdy[d], 27'(cur_wi(d))}, 32'(0));
    endtask

    task automatic run_frame(input int d, input int len, input logic [127:0] k, input int ivm,
                             input int orm, input bit poke, input int abort_at);
        int   total, bitn, g;
        bit   took;
        logic ivt;
        for (int i = 0; i <= len; i++)
            exp_w[d][i] = stim_a[i] ^ stim_b[i] ^ k[8 * (i % 16) +: 8];
        nw[d]      = len + 1;
        or_mode[d] = orm;
        fid[d]     = fid[d] + 1;
        start_s[d] = 1'b1;
        key_s[d]   = k;
        fl_s[d]    = 5'(len);
        @(posedge clk);
        #1;
        start_s[d] = 1'b0;
        chk(bsy[d] == 1'b1, "busy_after_start", 32'(bsy[d]), 32'(1));
        chk(dn[d] == 1'b0, "done_cleared", 32'(dn[d]), 32'(0));
        total = 8 * (len + 1);
        bitn  = 0;
        g     = 0;
        ivt   = 1'b0;
        while (bitn < total && g < 20000) begin
            a_s[d] = stim_a[bitn / 8][7 - bitn % 8];
            b_s[d] = stim_b[bitn / 8][7 - bitn % 8];
            case (ivm)
                0:       iv_s[d] = 1'b1;
                1:       begin ivt = ~ivt; iv_s[d] = ivt; end
                default: iv_s[d] = 1'($urandom % 2);
            endcase
            if (poke) begin
                start_s[d] = (bitn == 3);
                key_s[d]   = ~k;
                fl_s[d]    = 5'd7;
            end
            took = iv_s[d] && irdy[d];
            @(posedge clk);
            #1;
            g++;
            if (took) bitn++;
        end
        iv_s[d]    = 1'b0;
        start_s[d] = 1'b0;
        chk(bitn == total, "input_timeout", 32'(bitn), 32'(total));
        chk(ov[d] == 1'b0, "latency_encrypt", 32'(ov[d]), 32'(0));
        @(posedge clk);
        #1;
        chk(ov[d] == 1'b1, "latency_output", 32'(ov[d]), 32'(1));
        g = 0;
        while (!dn[d] && g < 5000) begin
            if (abort_at > 0 && pos[d] >= abort_at) begin
                #2;
                rst = 1'b1;
                #1;
                check_all_zero(d, "async_reset_outputs");
                @(posedge clk);
                #1;
                rst = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
            g++;
        end
        chk(dn[d] == 1'b1, "done_set", 32'(dn[d]), 32'(1));
        chk(bsy[d] == 1'b0, "idle_after_done", 32'(bsy[d]), 32'(0));
        chk(pos[d] == total, "bits_emitted", 32'(pos[d]), 32'(total));
    endtask

    task automatic set_stim(input logic [7:0] a, input logic [7:0] b);
        for (int i = 0; i < 64; i++) begin
            stim_a[i] = a;
            stim_b[i] = b;
        end
    endtask

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            start_s[d] = 1'b0; a_s[d] = 1'b0; b_s[d] = 1'b0; iv_s[d] = 1'b0;
            fl_s[d] = '0; key_s[d] = '0; or_mode[d] = 0; nw[d] = 0; fid[d] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        check_all_zero(0, "reset_state_0");
        check_all_zero(1, "reset_state_1");
        rst = 1'b0;
        @(posedge clk);
        #1;

        set_stim(8'hF0, 8'h0F);
        run_frame(0, 0, c_key, 0, 0, 1'b0, 0);
        chk(rcv[0][0] == 8'hCB, "t1_word", 32'(rcv[0][0]), 32'hCB);

        set_stim(8'h00, 8'h00);
        run_frame(0, 1, c_key, 0, 0, 1'b0, 0);
        chk(rcv[0][0] == 8'h34, "t2_word0", 32'(rcv[0][0]), 32'h34);
        chk(rcv[0][1] == 8'h12, "t2_word1", 32'(rcv[0][1]), 32'h12);

        set_stim(8'hF0, 8'h0F);
        run_frame(0, 0, c_key, 1, 0, 1'b0, 0);
        chk(rcv[0][0] == 8'hCB, "t3_toggle_valid", 32'(rcv[0][0]), 32'hCB);
        run_frame(0, 0, c_key, 0, 2, 1'b0, 0);
        chk(rcv[0][0] == 8'hCB, "t3_stall", 32'(rcv[0][0]), 32'hCB);

        run_frame(1, 0, c_key, 0, 0, 1'b0, 0);
        chk(rcv[1][0] == 8'hCB, "t4_lsb_first", 32'(rcv[1][0]), 32'hCB);

        run_frame(0, 0, c_key, 0, 0, 1'b1, 0);
        chk(rcv[0][0] == 8'hCB, "t5_start_ignored", 32'(rcv[0][0]), 32'hCB);
        run_frame(0, 0, c_key, 0, 0, 1'b0, 3);
        run_frame(0, 0, c_key, 0, 0, 1'b0, 0);
        chk(rcv[0][0] == 8'hCB, "t5_after_reset", 32'(rcv[0][0]), 32'hCB);

        set_stim(8'h00, 8'h00);
        run_frame(1, 16, c_key, 0, 0, 1'b0, 0);
        chk(rcv[1][0] == 8'h34, "t6_word0", 32'(rcv[1][0]), 32'h34);
        chk(rcv[1][2] == 8'hEF, "t6_word2", 32'(rcv[1][2]), 32'hEF);
        chk(rcv[1][15] == 8'hA1, "t6_word15", 32'(rcv[1][15]), 32'hA1);
        chk(rcv[1][16] == 8'h34, "t6_key_wrap", 32'(rcv[1][16]), 32'h34);

        for (int r = 0; r < 6; r++) begin
            for (int d = 0; d < 2; d++) begin
                logic [127:0] k;
                int           len;
                k   = {$urandom, $urandom, $urandom, $urandom};
                len = (d == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 31));
                for (int i = 0; i < 64; i++) begin
                    stim_a[i] = 8'($urandom);
                    stim_b[i] = 8'($urandom);
                end
                run_frame(d, len, k, 2, 1, 1'b0, 0);
                for (int i = 0; i <= len; i++)
                    chk(rcv[d][i] == exp_w[d][i], "rand_word", 32'(rcv[d][i]), 32'(exp_w[d][i]));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
